// File: rtl/boot_ctrl.sv
// rtl/boot_ctrl.sv - byte-stream boot loader that writes a length-prefixed image into SRAM
//
// Purpose: receives a 4-byte word count followed by that many 4-byte words
// (all MSB first) and writes each word to consecutive SRAM word addresses
// starting at BASE_ADDR. The build macro BOOT_CTRL_CHECKSUM_EN adds a 4-byte
// trailer holding the modulo-2^32 sum of all words; a mismatch aborts the load.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   boot_start        single-cycle load request (honoured in IDLE/DONE/ERR only)
//   rx_valid, rx_data byte source; a byte moves when rx_valid & rx_ready
//   rx_ready          controller can take a byte (LEN, DATA, CHECK)
//   boot_mode         steers the SRAM mux to the boot path while loading
//   boot_mem_wr_en    one-cycle SRAM write strobe
//   boot_mem_addr     SRAM word address (holds its last value)
//   boot_mem_rd_data  SRAM write data (holds its last value)
//   boot_done         image loaded successfully
//   boot_err          load aborted (length too large, timeout, bad checksum)
module boot_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 20,
  parameter int BASE_ADDR      = 0,
  parameter int MAX_WORDS      = 65536,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  boot_mode,
  output logic                  boot_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] boot_mem_addr,
  output logic [DATA_WIDTH-1:0] boot_mem_rd_data,
  output logic                  boot_done,
  output logic                  boot_err
);

`ifdef BOOT_CTRL_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR} state_t;
  // After the last word the trailer must be verified before declaring success.
  localparam state_t FIN = CHECK;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;
  localparam state_t FIN = DONE;
`endif

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] len_words;
  logic [23:0] shift;
  logic [31:0] tmo_cnt;
`ifdef BOOT_CTRL_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic        accept;
  logic        last_byte;
  logic        timed_out;
  logic        start_load;
  logic [31:0] byte_word;

  assign accept     = rx_valid & rx_ready;
  assign last_byte  = accept && (byte_cnt == 2'd3);
  // Word including the byte arriving this cycle, so decisions need no extra stage.
  assign byte_word  = {shift, rx_data};
  assign timed_out  = (tmo_cnt >= 32'(TIMEOUT_CYCLES));
  assign start_load = boot_start && (state == IDLE || state == DONE || state == ERR);

  always_comb begin
    state_nxt      = state;
    rx_ready       = 1'b0;
    boot_mode      = 1'b0;
    boot_mem_wr_en = 1'b0;
    boot_done      = 1'b0;
    boot_err       = 1'b0;
    case (state)
      IDLE: begin
        if (boot_start) state_nxt = LEN;
      end
      LEN: begin
        rx_ready  = 1'b1;
        boot_mode = 1'b1;
        if (timed_out) state_nxt = ERR;
        else if (last_byte) begin
          if (byte_word > 32'(MAX_WORDS)) state_nxt = ERR;
          else if (byte_word == 32'd0)    state_nxt = FIN;
          else                            state_nxt = DATA;
        end
      end
      DATA: begin
        rx_ready  = 1'b1;
        boot_mode = 1'b1;
        if (timed_out)      state_nxt = ERR;
        else if (last_byte) state_nxt = WRITE;
      end
      WRITE: begin
        boot_mode      = 1'b1;
        boot_mem_wr_en = 1'b1;
        // word_cnt is still the index of the word being written here.
        if (word_cnt + 32'd1 < len_words) state_nxt = DATA;
        else                              state_nxt = FIN;
      end
`ifdef BOOT_CTRL_CHECKSUM_EN
      CHECK: begin
        rx_ready  = 1'b1;
        boot_mode = 1'b1;
        if (timed_out)      state_nxt = ERR;
        else if (last_byte) state_nxt = (byte_word == checksum) ? DONE : ERR;
      end
`endif
      DONE: begin
        boot_done = 1'b1;
        if (boot_start) state_nxt = LEN;
      end
      ERR: begin
        boot_err = 1'b1;
        if (boot_start) state_nxt = LEN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      byte_cnt         <= '0;
      word_cnt         <= '0;
      len_words        <= '0;
      shift            <= '0;
      tmo_cnt          <= '0;
      boot_mem_addr    <= '0;
      boot_mem_rd_data <= '0;
`ifdef BOOT_CTRL_CHECKSUM_EN
      checksum         <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (start_load) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        tmo_cnt  <= '0;
`ifdef BOOT_CTRL_CHECKSUM_EN
        checksum <= '0;
`endif
      end else begin
        if (accept) begin
          tmo_cnt  <= '0;
          byte_cnt <= byte_cnt + 2'd1;
          shift    <= byte_word[23:0];
        end else if (rx_ready) begin
          // rx_ready is high exactly in the states where idle time is counted.
          tmo_cnt <= tmo_cnt + 32'd1;
        end
        if (state == LEN && last_byte) len_words <= byte_word;
        if (state == DATA && last_byte) begin
          boot_mem_addr    <= ADDR_WIDTH'(32'(BASE_ADDR) + word_cnt);
          boot_mem_rd_data <= byte_word;
        end
        if (state == WRITE) begin
          word_cnt <= word_cnt + 32'd1;
`ifdef BOOT_CTRL_CHECKSUM_EN
          checksum <= checksum + boot_mem_rd_data;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// tb/tb_boot_ctrl.sv - scoreboard bench for boot_ctrl (directed vectors)
module tb_boot_ctrl;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        boot_mode;
  logic        boot_mem_wr_en;
  logic [19:0] boot_mem_addr;
  logic [31:0] boot_mem_rd_data;
  logic        boot_done;
  logic        boot_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  boot_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(20), .BASE_ADDR(0),
    .MAX_WORDS(65536), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .boot_mode(boot_mode), .boot_mem_wr_en(boot_mem_wr_en),
    .boot_mem_addr(boot_mem_addr), .boot_mem_rd_data(boot_mem_rd_data),
    .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && boot_mem_wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", boot_mem_addr, boot_mem_rd_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (boot_mem_addr !== e.addr || boot_mem_rd_data !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   boot_mem_addr, boot_mem_rd_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_wait: got 0, expected 1 within 50 cycles");
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic push_wr(input logic [19:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_end(input string name, input int max_cycles, output int cycles);
    cycles = 0;
    while (!(boot_done || boot_err) && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
    end
    if (!(boot_done || boot_err)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done/err, expected one within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic check_end(input string name, input logic done_exp);
    check({name, "_done"}, 32'(boot_done), 32'(done_exp));
    check({name, "_err"}, 32'(boot_err), 32'(!done_exp));
    check({name, "_mode"}, 32'(boot_mode), 32'd0);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({name, "_mode"}, 32'(boot_mode), 32'd0);
    check({name, "_wr_en"}, 32'(boot_mem_wr_en), 32'd0);
    check({name, "_addr"}, 32'(boot_mem_addr), 32'd0);
    check({name, "_data"}, boot_mem_rd_data, 32'd0);
    check({name, "_done"}, 32'(boot_done), 32'd0);
    check({name, "_err"}, 32'(boot_err), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n      = 1'b0;
    boot_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word image
    pulse_start();
    push_wr(20'd0, 32'h11223344);
    push_wr(20'd1, 32'hAABBCCDD);
    send_word(32'd2);
    send_word(32'h11223344);
    send_word(32'hAABBCCDD);
`ifdef BOOT_CTRL_CHECKSUM_EN
    send_word(32'hBBDE0021);
`endif
    wait_end("len2", 50, cyc);
    check_end("len2", 1'b1);

    // Zero-length image
    pulse_start();
    send_word(32'd0);
`ifdef BOOT_CTRL_CHECKSUM_EN
    @(negedge clk);
    check("len0_check_ready", 32'(rx_ready), 32'd1);
    check("len0_check_mode", 32'(boot_mode), 32'd1);
    send_word(32'h00000000);
`endif
    wait_end("len0", 20, cyc);
    check_end("len0", 1'b1);

    // Length one beyond the limit
    pulse_start();
    send_word(32'd65537);
    wait_end("len_big", 20, cyc);
    check_end("len_big", 1'b0);

    // Stall after two data bytes
    pulse_start();
    send_word(32'd1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    wait_end("stall", TMO + 50, cyc);
    check_end("stall", 1'b0);
    checks++;
    if (cyc < TMO || cyc > TMO + 2) begin
      errors++;
      $display("FAIL stall_latency: got %0d cycles, expected %0d..%0d", cyc, TMO, TMO + 2);
    end

    // Reset mid-word, then a clean reload
    pulse_start();
    send_word(32'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    push_wr(20'd0, 32'hCAFEF00D);
    send_word(32'd1);
    send_word(32'hCAFEF00D);
`ifdef BOOT_CTRL_CHECKSUM_EN
    send_word(32'hCAFEF00D);
`endif
    wait_end("reload", 50, cyc);
    check_end("reload", 1'b1);

`ifdef BOOT_CTRL_CHECKSUM_EN
    // Checksum match and mismatch
    pulse_start();
    push_wr(20'd0, 32'h1);
    push_wr(20'd1, 32'h2);
    send_word(32'd2);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    wait_end("csum_ok", 20, cyc);
    check_end("csum_ok", 1'b1);

    pulse_start();
    push_wr(20'd0, 32'h1);
    push_wr(20'd1, 32'h2);
    send_word(32'd2);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h4);
    wait_end("csum_bad", 20, cyc);
    check_end("csum_bad", 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line.
- DATA_WIDTH, 32, SRAM word width; fixed at 32 (4 bytes per word).
- ADDR_WIDTH, 20, SRAM word-address width.
- BASE_ADDR, 0, first SRAM word address written.
- MAX_WORDS, 65536, largest legal image length in words.
- TIMEOUT_CYCLES, 1000000, idle-byte limit in cycles while loading.
REQ-002 Ports SHALL be as follows, one per line.
- clk  in  1  the single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- boot_start  in  1  single-cycle request to begin a load.
- rx_valid  in  1  rx_data holds a byte.
- rx_data  in  8  received byte.
- rx_ready  out  1  controller accepts a byte this cycle.
- boot_mode  out  1  selects the boot path in the SRAM mux.
- boot_mem_wr_en  out  1  SRAM write strobe.
- boot_mem_addr  out  ADDR_WIDTH  SRAM write address.
- boot_mem_rd_data  out  DATA_WIDTH  SRAM write data (name matches the mux input).
- boot_done  out  1  image loaded successfully.
- boot_err  out  1  load aborted.

Function
REQ-003 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-004 The FSM SHALL have these states: IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR.
REQ-005 rx_ready SHALL be 1 only in LEN, DATA and CHECK.
REQ-006 boot_mode SHALL be 1 only in LEN, DATA, WRITE and CHECK.
REQ-007 In IDLE, DONE or ERR, boot_start=1 SHALL do all of the following:
- clear boot_done and boot_err;
- clear the byte counter, word counter and checksum;
- enter LEN.
REQ-008 boot_start SHALL be ignored in LEN, DATA, WRITE and CHECK.
REQ-009 LEN SHALL accept 4 bytes, MSB first, as the 32-bit word count N.
REQ-010 On the 4th LEN byte, the FSM SHALL go as follows:
- to ERR if N > MAX_WORDS;
- to CHECK (macro defined) or DONE (macro undefined) if N = 0;
- to DATA otherwise.
REQ-011 DATA SHALL assemble 4 bytes, MSB first, into one word; the 4th byte SHALL move the FSM to WRITE.
REQ-012 WRITE SHALL last exactly 1 cycle, with:
- boot_mem_wr_en = 1;
- boot_mem_addr = BASE_ADDR + k, where k is the 0-based word index, truncated to ADDR_WIDTH bits;
- boot_mem_rd_data = the assembled word.
REQ-013 Write latency SHALL be 1 cycle: 4th byte accepted in cycle t gives the write strobe in cycle t+1.
REQ-014 After WRITE, the FSM SHALL go to DATA if k+1 < N; otherwise to CHECK (macro defined) or DONE.
REQ-015 boot_mem_wr_en SHALL be 0 outside WRITE; boot_mem_addr and boot_mem_rd_data SHALL hold their last values.
REQ-016 A timeout counter SHALL clear on every accepted byte and on entry to LEN, and SHALL count every cycle spent in LEN, DATA or CHECK.
REQ-017 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL enter ERR.
REQ-018 DONE SHALL hold boot_done = 1; ERR SHALL hold boot_err = 1; both states hold until the next boot_start.
REQ-019 boot_done and boot_err SHALL never both be 1.

Reset
REQ-020 rst_n = 0 SHALL immediately set:
- state = IDLE;
- boot_mode, boot_mem_wr_en, rx_ready, boot_done, boot_err = 0;
- boot_mem_addr, boot_mem_rd_data and all counters = 0.
REQ-021 Reset mid-load SHALL abandon the transfer with no further write strobe; a partial image SHALL be left in SRAM.

Configuration
REQ-022 Macro BOOT_CTRL_CHECKSUM_EN, when defined, SHALL enable the checksum check:
- a 32-bit checksum, the sum modulo 2^32 of all written words, is kept;
- CHECK accepts 4 bytes, MSB first, as the expected sum;
- on a match the FSM enters DONE, on a mismatch it enters ERR.
REQ-023 When BOOT_CTRL_CHECKSUM_EN is undefined, CHECK and the checksum logic SHALL be absent, and no trailer bytes SHALL be consumed.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Length 2, words 0x11223344 and 0xAABBCCDD -> strobes at addr 0 then 1 with those data; boot_done = 1; boot_mode = 0 afterwards.
- Length 0 -> no strobe; boot_done (macro off), or CHECK expecting 0x00000000 (macro on).
- Length MAX_WORDS+1 -> boot_err = 1 with no strobe.
- Stall TIMEOUT_CYCLES after 2 data bytes -> boot_err = 1; boot_mode = 0.
- rst_n pulsed low mid-word -> all outputs 0 at once; a new boot_start loads correctly.
- Macro on, words 0x1 and 0x2, trailer 0x00000003 -> boot_done; trailer 0x00000004 -> boot_err.
